// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the sequence-detector feeder path
// Provides the serializer state encoding and the counter-width helper.
package seq_det_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: word-to-bit serializer with one-word hold register feeding a serial detector
// Ports: clk, rst (sync, active-high); s_valid/s_data/s_ready word handshake;
//        bit_en advance strobe; bit_out/bit_valid serial data; word_done last-bit pulse; busy.
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             bit_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, hold;
    logic             hold_valid, accept, adv, load, cur_bit, first_bit;

    function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endfunction

    assign s_ready = !hold_valid && !rst;
    assign accept  = s_valid && s_ready;
    assign busy    = (state == SHIFT) || hold_valid;

    // cnt is the index of the bit currently on the line; reaching LAST means the
    // word is fully out and the next strobe either reloads from hold or idles.
    always_comb begin
        adv       = bit_en && (state == SHIFT) && (cnt != LAST);
        load      = bit_en && !adv && hold_valid;
        state_nxt = bit_en ? ((adv || load) ? SHIFT : IDLE) : state;
        cur_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        first_bit = MSB_FIRST ? hold[WIDTH-1] : hold[0];
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold       <= '0;
            shreg      <= '0;
            cnt        <= '0;
            bit_out    <= IDLE_BIT;
            bit_valid  <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            word_done <= adv && (cnt == PENULT);
            if (accept) begin
                hold       <= s_data;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
            if (adv) begin
                bit_out   <= cur_bit;
                shreg     <= shift(shreg);
                cnt       <= cnt + 1'b1;
                bit_valid <= 1'b1;
            end else if (load) begin
                bit_out   <= first_bit;
                shreg     <= shift(hold);
                cnt       <= '0;
                bit_valid <= 1'b1;
            end else if (bit_en) begin
                bit_out   <= IDLE_BIT;
                bit_valid <= 1'b0;
                cnt       <= '0;
            end
        end
    end
endmodule
